// File: rtl/friscv_pkg.sv
// Shared sizing helpers for the scoreboard: register count, unit-id width, counter width.
// Pure elaboration-time functions; no state and no timing of their own.
package friscv_pkg;

    function automatic int regnum(input int rv32e);
        return (rv32e != 0) ? 16 : 32;
    endfunction

    function automatic int addr_w(input int rv32e);
        return (rv32e != 0) ? 4 : 5;
    endfunction

    function automatic int unit_w(input int nb_alu_unit);
        return (nb_alu_unit > 1) ? $clog2(nb_alu_unit) : 1;
    endfunction

    function automatic int cnt_w(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/friscv_scoreboard_if.sv
// Issue handshake from the controller plus the per-unit writeback strobes seen by the scoreboard.
// issue_ready is combinational on the scoreboard side and independent of issue_valid.
interface friscv_scoreboard_if #(
    parameter int NB_ALU_UNIT = 2
);
    import friscv_pkg::*;

    localparam int UNIT_W = unit_w(NB_ALU_UNIT);

    logic                       issue_valid;
    logic                       issue_ready;
    logic [4:0]                 issue_rs1_addr;
    logic [4:0]                 issue_rs2_addr;
    logic                       issue_rd_en;
    logic [4:0]                 issue_rd_addr;
    logic [UNIT_W-1:0]          issue_unit;
    logic [NB_ALU_UNIT-1:0]     proc_rd_wr;
    logic [NB_ALU_UNIT*5-1:0]   proc_rd_addr;

    modport master (
        output issue_valid,
        output issue_rs1_addr,
        output issue_rs2_addr,
        output issue_rd_en,
        output issue_rd_addr,
        output issue_unit,
        output proc_rd_wr,
        output proc_rd_addr,
        input  issue_ready
    );

    modport slave (
        input  issue_valid,
        input  issue_rs1_addr,
        input  issue_rs2_addr,
        input  issue_rd_en,
        input  issue_rd_addr,
        input  issue_unit,
        input  proc_rd_wr,
        input  proc_rd_addr,
        output issue_ready
    );

endinterface

// File: rtl/friscv_scoreboard_cnt.sv
// Per-unit outstanding-write counter: increments on dispatch, decrements on writeback, saturates both ways.
// Updates on the next edge; full/zero are decoded from the registered count.
module friscv_scoreboard_cnt #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic srst,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic zero
);

    logic [CNT_W-1:0] cnt_q;

    assign full = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign zero = (cnt_q == '0);

    // A simultaneous inc and dec cancel out, even when the count sits at zero.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else if (srst || clr) begin
            cnt_q <= '0;
        end else if (inc && !dec && !full) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (dec && !inc && !zero) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/friscv_scoreboard.sv
// Register hazard tracker: per-register busy bit and owner unit, set on dispatch, cleared on owner writeback.
// issue_ready is combinational from registered state (no writeback bypass); state updates on the next edge.
module friscv_scoreboard
    import friscv_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int RV32E           = 0,
    parameter int NB_ALU_UNIT     = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    input  logic                  flush,
    friscv_scoreboard_if.slave    sb,
    output logic [31:0]           busy,
    output logic                  idle,
    output logic                  wb_error
);

    localparam int REGNUM = regnum(RV32E);
    localparam int AW     = addr_w(RV32E);
    localparam int UNIT_W = unit_w(NB_ALU_UNIT);
    localparam int CNT_W  = cnt_w(MAX_OUTSTANDING);

    if (RV32E != 0 && XLEN != 32) begin : g_bad_xlen
        $error("friscv_scoreboard: RV32E requires XLEN=32");
    end
    if (MAX_OUTSTANDING < 1) begin : g_bad_max
        $error("friscv_scoreboard: MAX_OUTSTANDING must be at least 1");
    end

    logic [REGNUM-1:0]      busy_q;
    logic [REGNUM-1:0]      busy_d;
    logic [UNIT_W-1:0]      owner_q [REGNUM];
    logic [UNIT_W-1:0]      owner_d [REGNUM];
    logic                   err_q;
    logic                   err_d;

    logic [NB_ALU_UNIT-1:0] cnt_full;
    logic [NB_ALU_UNIT-1:0] cnt_zero;
    logic [NB_ALU_UNIT-1:0] cnt_inc;
    logic [AW-1:0]          wb_idx [NB_ALU_UNIT];

    logic [AW-1:0]          rs1_idx;
    logic [AW-1:0]          rs2_idx;
    logic [AW-1:0]          rd_idx;
    logic                   unit_full;
    logic                   hazard;
    logic                   accept;
    logic                   unused_addr;

    // In RV32E the top address bit is dropped; the controller only issues legal indices.
    assign rs1_idx = sb.issue_rs1_addr[AW-1:0];
    assign rs2_idx = sb.issue_rs2_addr[AW-1:0];
    assign rd_idx  = sb.issue_rd_addr[AW-1:0];
    assign unused_addr = ^{sb.issue_rs1_addr, sb.issue_rs2_addr, sb.issue_rd_addr, sb.proc_rd_addr};

    for (genvar u = 0; u < NB_ALU_UNIT; u++) begin : g_wb_idx
        assign wb_idx[u] = sb.proc_rd_addr[u*5 +: AW];
    end

    // Unit ids beyond NB_ALU_UNIT-1 never match, so they read as full and stall.
    always_comb begin
        unit_full = 1'b1;
        for (int u = 0; u < NB_ALU_UNIT; u++) begin
            if (sb.issue_unit == UNIT_W'(u)) begin
                unit_full = cnt_full[u];
            end
        end
    end

    always_comb begin
        hazard = 1'b0;
        if (rs1_idx != '0 && busy_q[rs1_idx]) hazard = 1'b1;
        if (rs2_idx != '0 && busy_q[rs2_idx]) hazard = 1'b1;
        if (sb.issue_rd_en && rd_idx != '0 && busy_q[rd_idx]) hazard = 1'b1;
        if (sb.issue_rd_en && unit_full) hazard = 1'b1;
        if (flush) hazard = 1'b1;
    end

    assign sb.issue_ready = !hazard;
    assign accept = sb.issue_valid && sb.issue_ready && sb.issue_rd_en && (rd_idx != '0);

    always_comb begin
        cnt_inc = '0;
        for (int u = 0; u < NB_ALU_UNIT; u++) begin
            cnt_inc[u] = accept && (sb.issue_unit == UNIT_W'(u));
        end
    end

    // Writebacks are judged against registered state, so a same-edge double
    // writeback clears through the owner and flags the other unit.
    always_comb begin
        busy_d  = busy_q;
        owner_d = owner_q;
        err_d   = err_q;
        for (int u = 0; u < NB_ALU_UNIT; u++) begin
            if (sb.proc_rd_wr[u] && wb_idx[u] != '0) begin
                if (busy_q[wb_idx[u]] && owner_q[wb_idx[u]] == UNIT_W'(u)) begin
                    busy_d[wb_idx[u]] = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
        if (accept) begin
            busy_d[rd_idx]  = 1'b1;
            owner_d[rd_idx] = sb.issue_unit;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            busy_q <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < REGNUM; i++) owner_q[i] <= '0;
        end else if (srst) begin
            busy_q <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < REGNUM; i++) owner_q[i] <= '0;
        end else begin
            busy_q  <= busy_d;
            err_q   <= err_d;
            owner_q <= owner_d;
        end
    end

    for (genvar u = 0; u < NB_ALU_UNIT; u++) begin : g_cnt
        friscv_scoreboard_cnt #(
            .MAX_OUTSTANDING (MAX_OUTSTANDING),
            .CNT_W           (CNT_W)
        ) u_cnt (
            .aclk    (aclk),
            .aresetn (aresetn),
            .srst    (srst),
            .clr     (flush),
            .inc     (cnt_inc[u]),
            .dec     (sb.proc_rd_wr[u]),
            .full    (cnt_full[u]),
            .zero    (cnt_zero[u])
        );
    end

    always_comb begin
        busy = '0;
        busy[REGNUM-1:0] = busy_q;
    end

    assign idle     = !(|busy_q) && (&cnt_zero);
    assign wb_error = err_q;

endmodule

// File: doc/friscv_scoreboard.md
Name: friscv_scoreboard

Overview:
- Hazard tracker directly upstream of friscv_registers. The central controller asks it before dispatching an instruction to a processing unit.
- It holds one busy bit and one owner-unit id per ISA register. Busy bits are set on dispatch and cleared when the owning unit writes back through the register file's proc_rd_* write ports.
- Dispatch is stalled while any source or destination register still has a write pending. This guarantees that register-file reads return committed values.

Parameters:
- XLEN, 32, architecture width; used only for RV32E/width consistency checks.
- RV32E, 0, 1 limits tracking to 16 registers (REGNUM=16), otherwise 32.
- NB_ALU_UNIT, 2, number of processing units; must match friscv_registers.
- MAX_OUTSTANDING, 4, maximum in-flight writes per unit (≥1).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous reset, active-low.
- srst  in  1  synchronous reset, active-high.
- flush  in  1  drop all pending tracking (trap/branch recovery).
- issue_valid  in  1  controller presents an instruction.
- issue_ready  out  1  no hazard; dispatch is accepted when valid&&ready.
- issue_rs1_addr  in  5  source 1 index.
- issue_rs2_addr  in  5  source 2 index.
- issue_rd_en  in  1  instruction writes rd.
- issue_rd_addr  in  5  destination index.
- issue_unit  in  $clog2(NB_ALU_UNIT) (min 1)  target processing unit.
- proc_rd_wr  in  NB_ALU_UNIT  per-unit writeback strobe (same signals as the register file write port).
- proc_rd_addr  in  NB_ALU_UNIT*5  per-unit writeback index.
- busy  out  32  registered busy vector; bits ≥ REGNUM tied to 0.
- idle  out  1  no register busy and all unit counters zero.
- wb_error  out  1  sticky: writeback to a non-busy register, or from a unit that is not the owner.

Behaviour:
- Reset (aresetn low, or srst high at a clock edge): busy=0, owners=0, counters=0, wb_error=0. The derived outputs are then idle=1 and issue_ready=1.
- Hazard check uses registered state only; there is no same-cycle writeback bypass. A dispatch therefore resumes one cycle after the clearing writeback edge.
- issue_ready=0 when any of the following holds, otherwise 1:
  - busy[rs1] with rs1≠0;
  - busy[rs2] with rs2≠0;
  - issue_rd_en && busy[rd] with rd≠0 (WAW);
  - issue_rd_en && cnt[issue_unit]==MAX_OUTSTANDING;
  - flush=1.
- issue_ready is combinational and must not depend on issue_valid.
- Accept (issue_valid && issue_ready && issue_rd_en && rd≠0): at the next edge, busy[rd]=1, owner[rd]=issue_unit, cnt[issue_unit]+1.
- Accept with rd_en=0 or rd=0: no state change.
- Writeback, per unit u with proc_rd_wr[u] and addr a:
  - cnt[u] decrements, saturating at 0.
  - If a≠0 && busy[a] && owner[a]==u: busy[a] cleared.
  - Otherwise (a≠0 and not busy, or owner mismatch): wb_error set, busy unchanged.
  - a==0: counter decrement only.
- Simultaneous events on one edge:
  - Accept and writeback on the same rd: the set wins and the new owner is recorded. WAW hazard blocks this legally; it only occurs after the same-cycle clear.
  - Increment and decrement on the same unit counter: the value is unchanged.
  - Multiple units writing back to the same register: the owner clears it, the non-owner raises wb_error.
- x0 is never busy.
- RV32E: address bit 4 is ignored for tracking; the controller guarantees legal indices.
- flush: all busy bits and counters are cleared at the next edge; wb_error is kept.
  - Writebacks arriving after a flush raise wb_error. The controller therefore asserts flush only once units have drained or been killed.
- idle is combinational from registered state.

Decomposition:
- Shared package friscv_pkg holds:
  - REGNUM derivation function;
  - UNIT_W = max(1, $clog2(NB_ALU_UNIT));
  - CNT_W = $clog2(MAX_OUTSTANDING+1).
- One natural sub-module, friscv_scoreboard_cnt: a per-unit saturating up/down counter with inc, dec, full and zero outputs. It is instantiated NB_ALU_UNIT times.

Test Plan:
- Reset: assert aresetn mid-run with x5 busy → busy=0, idle=1, issue_ready=1 immediately, without waiting for a clock edge.
- RAW: dispatch rd=x5 on unit 0, then present rs1=x5 → issue_ready=0. Unit 0 writes back x5 at edge N → issue_ready=1 in cycle N+1 and busy[5]=0.
- WAW and x0:
  - dispatch rd=x0 → busy stays 0, cnt unchanged;
  - dispatch rd=x7 on unit 1, then rd=x7 on unit 0 → stalled until unit 1 writes back x7.
- Counter full: MAX_OUTSTANDING=4, four dispatches to unit 0 (x1..x4) → fifth (rd=x6) stalled. One writeback x1 → accepted the following cycle with cnt=4.
- Errors: unit 1 writes back x3 while owner is unit 0 → wb_error=1 and busy[3] stays 1. Unit 0 writes back x9 (not busy) → wb_error stays 1 until srst.
- Flush: x2, x8, x10 busy with cnt0=2, cnt1=1; assert flush → issue_ready=0 that cycle, then busy=0, idle=1, wb_error unchanged.
